// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: control sequencer for a time-multiplexed FIR datapath.
// Accepts one sample per in_valid/in_ready handshake and writes it into the
// circular sample RAM. It then issues TAPS MAC terms, newest sample first,
// with matching coefficient addresses, waits out the MAC pipeline, pulses
// acc_load and presents the result on out_valid/out_ready.
//
// Optional feature: define FIR_FLUSH_EN to zero the sample RAM after every
// reset (FLUSH state). Without it, reset goes straight to IDLE and smp_wzero
// stays 0.
//
// Ports:
//   clk, rst          clock (rising edge); asynchronous reset, active low
//   in_valid/ready    input sample handshake
//   out_valid/ready   result handshake
//   smp_we/wzero      sample RAM write strobe / write zero instead of sample
//   smp_waddr/raddr   sample RAM write / read address
//   coef_addr         coefficient ROM address
//   mac_en/clr/last   issue a MAC term / first term / final term
//   acc_load          latch the rounded accumulator into the output register
module fir_mac_sequencer #(
   parameter int unsigned TAPS    = 401,
   parameter int unsigned AW      = 9,
   parameter int unsigned MAC_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          smp_we,
   output logic          smp_wzero,
   output logic [AW-1:0] smp_waddr,
   output logic [AW-1:0] smp_raddr,
   output logic [AW-1:0] coef_addr,
   output logic          mac_en,
   output logic          mac_clr,
   output logic          mac_last,
   output logic          acc_load
);

   localparam int unsigned DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
   localparam logic [DW-1:0] LAST_D   = DW'(MAC_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MAC   = 3'd1,
      S_DRAIN = 3'd2,
      S_OUT   = 3'd3,
      S_FLUSH = 3'd4
   } state_t;

`ifdef FIR_FLUSH_EN
   localparam state_t RST_STATE = S_FLUSH;
`else
   localparam state_t RST_STATE = S_IDLE;
`endif

   state_t        state;
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW-1:0] k;
   logic [DW-1:0] d;
`ifdef FIR_FLUSH_EN
   logic [AW-1:0] f;
`endif

   // State, pointers and counters; the read pointer walks backwards from the
   // newest sample so tap k pairs with coefficient k.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RST_STATE;
         wptr  <= '0;
         rptr  <= '0;
         k     <= '0;
         d     <= '0;
`ifdef FIR_FLUSH_EN
         f     <= '0;
`endif
      end else begin
         case (state)
`ifdef FIR_FLUSH_EN
            S_FLUSH: begin
               f <= f + AW'(1);
               if (f == LAST_TAP) state <= S_IDLE;
            end
`endif
            S_IDLE: begin
               if (in_valid) begin
                  rptr  <= wptr;
                  k     <= '0;
                  wptr  <= (wptr == LAST_TAP) ? '0 : wptr + AW'(1);
                  state <= S_MAC;
               end
            end
            S_MAC: begin
               k    <= k + AW'(1);
               rptr <= (rptr == '0) ? LAST_TAP : rptr - AW'(1);
               if (k == LAST_TAP) begin
                  d     <= '0;
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               d <= d + DW'(1);
               if (d == LAST_D) state <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= RST_STATE;
         endcase
      end
   end

   // Output decode; everything is forced low while reset is asserted and
   // addresses stay zero whenever their strobe is low.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      smp_we    = 1'b0;
      smp_wzero = 1'b0;
      smp_waddr = '0;
      smp_raddr = '0;
      coef_addr = '0;
      mac_en    = 1'b0;
      mac_clr   = 1'b0;
      mac_last  = 1'b0;
      acc_load  = 1'b0;
      if (rst) begin
         case (state)
`ifdef FIR_FLUSH_EN
            S_FLUSH: begin
               smp_we    = 1'b1;
               smp_wzero = 1'b1;
               smp_waddr = f;
            end
`endif
            S_IDLE: begin
               in_ready  = 1'b1;
               smp_we    = in_valid;
               smp_waddr = in_valid ? wptr : '0;
            end
            S_MAC: begin
               mac_en    = 1'b1;
               coef_addr = k;
               smp_raddr = rptr;
               mac_clr   = (k == '0);
               mac_last  = (k == LAST_TAP);
            end
            S_DRAIN: acc_load  = (d == LAST_D);
            S_OUT:   out_valid = 1'b1;
            default: ;
         endcase
      end
   end

endmodule
